// File: rtl/vga_pkg.sv
// Shared VGA constants: visible-area timing, sprite palette and colour-word layout.
package vga_pkg;

    localparam int H_ACTIVE = 640;
    localparam int V_ACTIVE = 480;
    localparam int POS_W    = 10;

    // Colour word layout: RRGGBB00
    localparam int R_MSB = 7;
    localparam int R_LSB = 6;
    localparam int G_MSB = 5;
    localparam int G_LSB = 4;
    localparam int B_MSB = 3;
    localparam int B_LSB = 2;

    function automatic logic [7:0] palette_color(input logic [2:0] idx);
        logic [7:0] c;
        case (idx)
            3'd0:    c = 8'hC0;
            3'd1:    c = 8'hF0;
            3'd2:    c = 8'h30;
            3'd3:    c = 8'h3C;
            3'd4:    c = 8'h0C;
            3'd5:    c = 8'hCC;
            3'd6:    c = 8'hFC;
            default: c = 8'h54;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/sprite_axis.sv
// One motion axis of the sprite: position and direction that bounce between 0 and MAX.
module sprite_axis #(
    parameter int MAX = 608
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       step_en,
    input  logic [2:0]                 step,
    output logic [vga_pkg::POS_W-1:0]  pos,
    output logic                       bounce
);
    import vga_pkg::*;

    localparam logic [POS_W:0] MAX_W = (POS_W+1)'(MAX);

    logic             dir;          // 0 = increasing, 1 = decreasing
    logic             dir_next;
    logic             hit;
    logic [POS_W-1:0] pos_next;
    logic [POS_W:0]   pos_w;
    logic [POS_W:0]   step_w;
    logic [POS_W:0]   sum;

    assign pos_w  = {1'b0, pos};
    assign step_w = {{(POS_W-2){1'b0}}, step};
    assign sum    = pos_w + step_w;

    always_comb begin
        pos_next = pos;
        dir_next = dir;
        hit      = 1'b0;
        if (!dir) begin
            if (sum >= MAX_W) begin
                pos_next = MAX_W[POS_W-1:0];
                dir_next = 1'b1;
                hit      = 1'b1;
            end else begin
                pos_next = sum[POS_W-1:0];
            end
        end else begin
            if (pos_w <= step_w) begin
                pos_next = '0;
                dir_next = 1'b0;
                hit      = 1'b1;
            end else begin
                pos_next = pos - step_w[POS_W-1:0];
            end
        end
    end

    assign bounce = step_en & hit;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pos <= '0;
            dir <= 1'b0;
        end else if (step_en) begin
            pos <= pos_next;
            dir <= dir_next;
        end
    end

endmodule

// File: rtl/bouncing_sprite.sv
// Pixel-colour stage: one solid sprite on a flat background, moved once per frame
// during vertical blanking and recoloured on every bounce.
module bouncing_sprite #(
    parameter int         H_ACTIVE = vga_pkg::H_ACTIVE,
    parameter int         V_ACTIVE = vga_pkg::V_ACTIVE,
    parameter int         SPRITE_W = 32,
    parameter int         SPRITE_H = 32,
    parameter logic [7:0] BG_COLOR = 8'h00
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [9:0] pix_x,
    input  logic [9:0] pix_y,
    input  logic       video_active,
    input  logic       pause,
    input  logic [1:0] speed,
    output logic [7:0] video_colored,
    output logic [7:0] bounce_count
);
    import vga_pkg::*;

    localparam int X_MAX = H_ACTIVE - SPRITE_W;
    localparam int Y_MAX = V_ACTIVE - SPRITE_H;

    logic       tick;
    logic       step_en;
    logic [2:0] step;
    logic [9:0] pos_x;
    logic [9:0] pos_y;
    logic       bounce_x;
    logic       bounce_y;
    logic       bounce_event;
    logic [2:0] color_idx;
    logic       hit;

    // First blanking line, column 0: happens exactly once per frame.
    assign tick    = (pix_y == 10'(V_ACTIVE)) && (pix_x == 10'd0);
    assign step_en = tick & ~pause;
    assign step    = {1'b0, speed} + 3'd1;

    sprite_axis #(.MAX(X_MAX)) u_axis_x (
        .clk     (clk),
        .rst_n   (rst_n),
        .step_en (step_en),
        .step    (step),
        .pos     (pos_x),
        .bounce  (bounce_x)
    );

    sprite_axis #(.MAX(Y_MAX)) u_axis_y (
        .clk     (clk),
        .rst_n   (rst_n),
        .step_en (step_en),
        .step    (step),
        .pos     (pos_y),
        .bounce  (bounce_y)
    );

    // A corner hit is a single event.
    assign bounce_event = bounce_x | bounce_y;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            color_idx    <= 3'd0;
            bounce_count <= 8'd0;
        end else if (bounce_event) begin
            color_idx    <= color_idx + 3'd1;
            bounce_count <= bounce_count + 8'd1;
        end
    end

    assign hit = ({1'b0, pix_x} >= {1'b0, pos_x}) &&
                 ({1'b0, pix_x} <  ({1'b0, pos_x} + 11'(SPRITE_W))) &&
                 ({1'b0, pix_y} >= {1'b0, pos_y}) &&
                 ({1'b0, pix_y} <  ({1'b0, pos_y} + 11'(SPRITE_H)));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            video_colored <= 8'h00;
        end else if (!video_active) begin
            video_colored <= 8'h00;
        end else if (hit) begin
            video_colored <= palette_color(color_idx);
        end else begin
            video_colored <= BG_COLOR;
        end
    end

endmodule

// File: tb/tb_bouncing_sprite.sv
// Directed bench for bouncing_sprite: a default-size instance plus a square-range
// instance (simultaneous corner hits) and a full-screen instance (a bounce every frame).
module tb_bouncing_sprite;

    logic       clk;
    logic       rst_n;
    logic [9:0] px [3];
    logic [9:0] py [3];
    logic       va [3];
    logic       ps [3];
    logic [1:0] sp [3];
    logic [7:0] vc [3];
    logic [7:0] bc [3];

    int compared;
    int mismatched;

    bouncing_sprite u_main (
        .clk(clk), .rst_n(rst_n), .pix_x(px[0]), .pix_y(py[0]), .video_active(va[0]),
        .pause(ps[0]), .speed(sp[0]), .video_colored(vc[0]), .bounce_count(bc[0])
    );

    bouncing_sprite #(.SPRITE_W(192), .SPRITE_H(32)) u_corner (
        .clk(clk), .rst_n(rst_n), .pix_x(px[1]), .pix_y(py[1]), .video_active(va[1]),
        .pause(ps[1]), .speed(sp[1]), .video_colored(vc[1]), .bounce_count(bc[1])
    );

    bouncing_sprite #(.SPRITE_W(640), .SPRITE_H(480)) u_wrap (
        .clk(clk), .rst_n(rst_n), .pix_x(px[2]), .pix_y(py[2]), .video_active(va[2]),
        .pause(ps[2]), .speed(sp[2]), .video_colored(vc[2]), .bounce_count(bc[2])
    );

    // clock / reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed=%02h expected=%02h", tag, obs, exp);
        end
    endtask

    // Drive one pixel; the registered colour is checked one clock later.
    task automatic probe(input int i, input logic [9:0] x, input logic [9:0] y,
                         input logic a, input logic [7:0] exp, input string tag);
        @(negedge clk);
        px[i] = x;
        py[i] = y;
        va[i] = a;
        @(posedge clk);
        #1;
        check(tag, vc[i], exp);
    endtask

    task automatic tick(input int i, input int n);
        repeat (n) begin
            @(negedge clk);
            px[i] = 10'd0;
            py[i] = 10'd480;
            @(negedge clk);
            px[i] = 10'd1;
            py[i] = 10'd481;
        end
    endtask

    initial begin
        compared   = 0;
        mismatched = 0;
        rst_n      = 1'b0;
        for (int i = 0; i < 3; i++) begin
            px[i] = 10'd0;
            py[i] = 10'd0;
            va[i] = 1'b0;
            ps[i] = 1'b0;
            sp[i] = 2'd3;
        end
        sp[1] = 2'd0;

        // reset and first frame
        probe(0, 10'd5, 10'd5, 1'b1, 8'h00, "reset_hold");
        check("reset_count", bc[0], 8'd0);
        @(negedge clk);
        rst_n = 1'b1;
        probe(0, 10'd5, 10'd5, 1'b1, 8'hC0, "after_reset_in");
        probe(0, 10'd40, 10'd5, 1'b1, 8'h00, "after_reset_bg");

        // motion at speed 3
        tick(0, 1);
        probe(0, 10'd4, 10'd4, 1'b1, 8'hC0, "t1_corner");
        probe(0, 10'd3, 10'd4, 1'b1, 8'h00, "t1_left");
        probe(0, 10'd35, 10'd4, 1'b1, 8'hC0, "t1_right_in");
        probe(0, 10'd36, 10'd4, 1'b1, 8'h00, "t1_right_out");
        probe(0, 10'd4, 10'd3, 1'b1, 8'h00, "t1_above");
        probe(0, 10'd4, 10'd35, 1'b1, 8'hC0, "t1_bottom_in");
        probe(0, 10'd4, 10'd36, 1'b1, 8'h00, "t1_bottom_out");
        tick(0, 1);
        probe(0, 10'd8, 10'd8, 1'b1, 8'hC0, "t2_corner");
        probe(0, 10'd7, 10'd8, 1'b1, 8'h00, "t2_left");
        check("t2_count", bc[0], 8'd0);

        // pause freezes everything; blanking forces black
        ps[0] = 1'b1;
        tick(0, 3);
        ps[0] = 1'b0;
        probe(0, 10'd8, 10'd8, 1'b1, 8'hC0, "pause_corner");
        probe(0, 10'd7, 10'd8, 1'b1, 8'h00, "pause_left");
        probe(0, 10'd8, 10'd7, 1'b1, 8'h00, "pause_above");
        check("pause_count", bc[0], 8'd0);
        probe(0, 10'd8, 10'd8, 1'b0, 8'h00, "blank_in_sprite");

        // Y bounce at the bottom edge
        tick(0, 109);
        probe(0, 10'd444, 10'd444, 1'b1, 8'hC0, "pre_ybounce");
        check("pre_ybounce_count", bc[0], 8'd0);
        tick(0, 1);
        check("ybounce_count", bc[0], 8'd1);
        probe(0, 10'd448, 10'd448, 1'b1, 8'hF0, "ybounce_corner");
        probe(0, 10'd447, 10'd448, 1'b1, 8'h00, "ybounce_left");
        probe(0, 10'd448, 10'd447, 1'b1, 8'h00, "ybounce_above");
        probe(0, 10'd479, 10'd479, 1'b1, 8'hF0, "ybounce_far");
        tick(0, 1);
        probe(0, 10'd452, 10'd444, 1'b1, 8'hF0, "yback_corner");
        probe(0, 10'd452, 10'd443, 1'b1, 8'h00, "yback_above");
        probe(0, 10'd451, 10'd444, 1'b1, 8'h00, "yback_left");

        // X bounce at the right edge
        tick(0, 38);
        check("pre_xbounce_count", bc[0], 8'd1);
        tick(0, 1);
        check("xbounce_count", bc[0], 8'd2);
        probe(0, 10'd608, 10'd288, 1'b1, 8'h30, "xbounce_corner");
        probe(0, 10'd607, 10'd288, 1'b1, 8'h00, "xbounce_left");
        probe(0, 10'd639, 10'd288, 1'b1, 8'h30, "xbounce_far");
        tick(0, 1);
        probe(0, 10'd604, 10'd284, 1'b1, 8'h30, "xback_corner");
        probe(0, 10'd603, 10'd284, 1'b1, 8'h00, "xback_left");
        check("xback_count", bc[0], 8'd2);

        // speed sampled on the tick: step 1
        sp[0] = 2'd0;
        tick(0, 1);
        sp[0] = 2'd3;
        probe(0, 10'd603, 10'd283, 1'b1, 8'h30, "speed0_corner");
        probe(0, 10'd602, 10'd283, 1'b1, 8'h00, "speed0_left");

        // mid-frame asynchronous reset
        @(negedge clk);
        px[0] = 10'd610;
        py[0] = 10'd290;
        va[0] = 1'b1;
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("midreset_color", vc[0], 8'h00);
        check("midreset_count", bc[0], 8'd0);
        @(negedge clk);
        rst_n = 1'b1;
        probe(0, 10'd0, 10'd0, 1'b1, 8'hC0, "midreset_origin");
        probe(0, 10'd32, 10'd0, 1'b1, 8'h00, "midreset_right");
        tick(0, 1);
        probe(0, 10'd4, 10'd4, 1'b1, 8'hC0, "midreset_t1_corner");
        probe(0, 10'd3, 10'd4, 1'b1, 8'h00, "midreset_t1_left");

        // simultaneous corner hit: one event, both directions flip
        tick(1, 447);
        check("corner_pre_count", bc[1], 8'd0);
        tick(1, 1);
        check("corner_count", bc[1], 8'd1);
        probe(1, 10'd448, 10'd448, 1'b1, 8'hF0, "corner_pos");
        probe(1, 10'd447, 10'd448, 1'b1, 8'h00, "corner_left");
        probe(1, 10'd448, 10'd447, 1'b1, 8'h00, "corner_above");
        tick(1, 1);
        probe(1, 10'd447, 10'd447, 1'b1, 8'hF0, "corner_back");
        probe(1, 10'd446, 10'd447, 1'b1, 8'h00, "corner_back_left");
        probe(1, 10'd447, 10'd446, 1'b1, 8'h00, "corner_back_above");
        check("corner_back_count", bc[1], 8'd1);

        // full-screen sprite: every tick is a bounce event
        for (int k = 1; k <= 256; k++) begin
            tick(2, 1);
            if (k == 1) begin
                check("wrap_k1_count", bc[2], 8'd1);
                probe(2, 10'd320, 10'd240, 1'b1, 8'hF0, "wrap_k1_color");
            end
            if (k == 3) begin
                probe(2, 10'd320, 10'd240, 1'b1, 8'h3C, "wrap_k3_color");
            end
            if (k % 8 == 0) begin
                check("wrap_count", bc[2], 8'(k));
                probe(2, 10'd320, 10'd240, 1'b1, 8'hC0, "wrap_color");
            end
        end
        check("wrap_final_count", bc[2], 8'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
